serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes `diff = a - b` LSB-first, one bit per clock. Each bit goes through a full-subtract cell (two cascaded `half_sub` equations) with the borrow held in a flip-flop. It sits directly downstream of the combinational half/full subtractor cells and trades area for latency. A start/busy/done handshake lets a controller sequence operations.

---
 rtl/serial_subtractor_if.sv | 16 +
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (output start, a, b, input busy, done, diff, borrow, overflow);
  modport slave  (input start, a, b, output busy, done, diff, borrow, overflow);
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor; SERIAL_SUB_OVERFLOW_EN adds the signed overflow flag
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_busy;
  logic             r_done;
  logic             r_borrow;

  logic [WIDTH-1:0] w_res_next;
  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic             w_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_accept     = 1'b0;
    w_state_next = r_state;
    w_a0         = r_a_sr[0];
    w_b0         = r_b_sr[0];
    // full subtractor as two cascaded half-subtract stages
    w_d          = w_a0 ^ w_b0 ^ r_br;
    w_br_next    = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    w_res_next   = r_res >> 1;
    w_res_next[WIDTH-1] = w_d;
    w_last       = (r_cnt == CW'(WIDTH - 1));
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_br     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_SHIFT);
      r_done <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_a_sr <= bus.a;
        r_b_sr <= bus.b;
        r_br   <= 1'b0;
        r_cnt  <= '0;
      end else if (r_state == S_SHIFT) begin
        r_a_sr <= r_a_sr >> 1;
        r_b_sr <= r_b_sr >> 1;
        r_br   <= w_br_next;
        r_res  <= w_res_next;
        r_cnt  <= r_cnt + 1'b1;
        // final bit lands straight in the visible result on entry to DONE
        if (w_last) begin
          r_diff   <= w_res_next;
          r_borrow <= w_br_next;
        end
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_a_sign;
  logic r_b_sign;
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sign   <= 1'b0;
      r_b_sign   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_sign <= bus.a[WIDTH-1];
        r_b_sign <= bus.b[WIDTH-1];
      end
      if ((r_state == S_SHIFT) && w_last) begin
        r_overflow <= (r_a_sign != r_b_sign) && (w_res_next[WIDTH-1] != r_a_sign);
      end
    end
  end

  assign bus.overflow = r_overflow;
`else
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.d  = a - b;
    e.br = (a < b);
`ifdef SERIAL_SUB_OVERFLOW_EN
    e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
`else
    e.ov = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge E0.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Observation only: k counts edges after E0, sampled at negedges.
  task automatic observe(input int budget, output bit seen, output int lat,
                         output int busy_n, output exp_t got);
    seen   = 1'b0;
    lat    = -1;
    busy_n = 0;
    got    = '0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done === 1'b1) begin
        seen   = 1'b1;
        lat    = k;
        got.d  = bus.diff;
        got.br = bus.borrow;
        got.ov = bus.overflow;
      end else if (bus.busy === 1'b1) begin
        busy_n++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.borrow, bus.overflow} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got %b expected 0000", {bus.busy, bus.done, bus.borrow, bus.overflow});
    end
    n_cmp++;
    if (bus.diff !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_diff got %h expected 00", bus.diff);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit seen; int lat; int busy_n; exp_t got; exp_t e;
    launch(8'h05, 8'h03);
    observe(20, seen, lat, busy_n, got);
    e = pop_exp();
    n_cmp++;
    if (!seen || lat != W) begin
      n_bad++;
      $display("FAIL basic_latency got seen=%0d lat=%0d expected lat=%0d", seen, lat, W);
    end
    n_cmp++;
    if (busy_n != W) begin
      n_bad++;
      $display("FAIL basic_busy_cycles got %0d expected %0d", busy_n, W);
    end
    n_cmp++;
    if (got !== e || e.d !== 8'h02) begin
      n_bad++;
      $display("FAIL basic_result got %h/%b/%b expected %h/%b/%b", got.d, got.br, got.ov, e.d, e.br, e.ov);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.diff !== 8'h02) begin
      n_bad++;
      $display("FAIL basic_done_fall got done=%b diff=%h expected done=0 diff=02", bus.done, bus.diff);
    end
  endtask

  task automatic run_table(input string tag, input logic [W-1:0] ta[4], input logic [W-1:0] tb[4]);
    bit seen; int lat; int busy_n; exp_t got; exp_t e;
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i]);
      observe(20, seen, lat, busy_n, got);
      e = pop_exp();
      n_cmp++;
      if (!seen || got.d !== e.d) begin
        n_bad++;
        $display("FAIL %s_diff[%0d] got %h expected %h", tag, i, got.d, e.d);
      end
      n_cmp++;
      if (got.br !== e.br || got.ov !== e.ov) begin
        n_bad++;
        $display("FAIL %s_flags[%0d] got br=%b ov=%b expected br=%b ov=%b", tag, i, got.br, got.ov, e.br, e.ov);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_borrow();
    logic [W-1:0] ta[4];
    logic [W-1:0] tb[4];
    ta = '{8'h03, 8'h00, 8'hFF, 8'h00};
    tb = '{8'h05, 8'h00, 8'hFF, 8'hFF};
    run_table("borrow", ta, tb);
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta[4];
    logic [W-1:0] tb[4];
    ta = '{8'h80, 8'h7F, 8'h40, 8'hC0};
    tb = '{8'h01, 8'hFF, 8'hC0, 8'h40};
    run_table("overflow", ta, tb);
  endtask

  task automatic test_start_ignored();
    int   n_done;
    exp_t e;
    n_done = 0;
    launch(8'h05, 8'h03);
    for (int k = 0; k < 21; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        e = pop_exp();
        n_cmp++;
        if (bus.diff !== e.d || bus.borrow !== e.br) begin
          n_bad++;
          $display("FAIL ignore_result got %h/%b expected %h/%b", bus.diff, bus.borrow, e.d, e.br);
        end
      end
    end
    n_cmp++;
    if (n_done != 1) begin
      n_bad++;
      $display("FAIL ignore_done_count got %0d expected 1", n_done);
    end
  endtask

  task automatic test_reset_abort();
    bit seen; int lat; int busy_n; exp_t got; exp_t e;
    int n_done;
    n_done = 0;
    launch(8'h5A, 8'h33);
    void'(sb.pop_back());
    for (int k = 1; k <= 4; k++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.borrow} !== 3'b000 || bus.diff !== 8'h00) begin
      n_bad++;
      $display("FAIL abort_cleared got busy=%b done=%b diff=%h borrow=%b expected 0/0/00/0",
               bus.busy, bus.done, bus.diff, bus.borrow);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done != 0) begin
      n_bad++;
      $display("FAIL abort_no_done got %0d expected 0", n_done);
    end
    launch(8'h10, 8'h20);
    observe(20, seen, lat, busy_n, got);
    e = pop_exp();
    n_cmp++;
    if (!seen || got.d !== 8'hF0 || got.br !== 1'b1 || got !== e) begin
      n_bad++;
      $display("FAIL abort_restart got %h/%b expected f0/1", got.d, got.br);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int           last_k;
    int           n_done;
    bit           have;
    logic [W-1:0] held;
    logic [W-1:0] na;
    logic [W-1:0] nb;
    exp_t         e;
    last_k = -1;
    n_done = 0;
    have   = 1'b0;
    held   = '0;
    na = W'($urandom);
    nb = W'($urandom);
    bus.start = 1'b1;
    bus.a     = na;
    bus.b     = nb;
    sb.push_back(model(na, nb));
    @(posedge clk);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        e = pop_exp();
        n_cmp++;
        if (bus.diff !== e.d || bus.borrow !== e.br || bus.overflow !== e.ov) begin
          n_bad++;
          $display("FAIL b2b_result got %h/%b/%b expected %h/%b/%b",
                   bus.diff, bus.borrow, bus.overflow, e.d, e.br, e.ov);
        end
        if (last_k >= 0) begin
          n_cmp++;
          if (k - last_k != W + 2) begin
            n_bad++;
            $display("FAIL b2b_interval got %0d expected %0d", k - last_k, W + 2);
          end
        end
        last_k = k;
        held   = bus.diff;
        have   = 1'b1;
        n_done++;
      end else if (have) begin
        n_cmp++;
        if (bus.diff !== held) begin
          n_bad++;
          $display("FAIL b2b_diff_stable got %h expected %h", bus.diff, held);
        end
      end
      na = W'($urandom);
      nb = W'($urandom);
      bus.a = na;
      bus.b = nb;
      if (k >= 20) bus.start = 1'b0;
      else if ((k + 1) % (W + 2) == 0) sb.push_back(model(na, nb));
    end
    n_cmp++;
    if (n_done != 3 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_done_count got %0d (pending %0d) expected 3 (pending 0)", n_done, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
